// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM on the core's d_* port; define DMEM_RANGE_CHECK_EN to drop out-of-range accesses and raise sticky d_err.
// Latency: writes commit at the sampling edge; a read sampled at edge T responds in the cycle after edge T+LATENCY-1 (LATENCY 1..4).
// Backpressure: none; one request per cycle sustained with no stall path, the core relies on the fixed read latency.
module dmem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] d_address,
   input  logic [31:0] d_data_write,
   input  logic        d_write_enable,
   input  logic        d_data_valid,
   output logic [31:0] d_data_read,
`ifdef DMEM_RANGE_CHECK_EN
   output logic        d_rsp_valid,
   output logic        d_err
`else
   output logic        d_rsp_valid
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // The response pipeline is only defined for 1..4 stages.
   generate
      if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
         $fatal(1, "dmem_responder: LATENCY=%0d outside legal range 1..4", LATENCY);
      end
   endgenerate

   logic [31:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  addr_oor;
   logic                  wr_en;
   logic                  rd_en;
   logic [31:0]           rd_word;
   logic                  fin_vld;
   logic [31:0]           fin_dat;
   logic                  rsp_valid_q;
   logic                  rsp_valid_d;
   logic [31:0]           data_read_q;
   logic [31:0]           data_read_d;

   // Full-word accesses only: byte-offset bits are dropped.
   assign word_idx = d_address[DEPTH_LOG2+1:2];

`ifdef DMEM_RANGE_CHECK_EN
   logic unused_addr_lsb;
   assign addr_oor        = |d_address[31:DEPTH_LOG2+2];
   assign unused_addr_lsb = ^d_address[1:0];
`else
   // Upper address bits are ignored, so the array aliases across the address space.
   logic unused_addr_bits;
   assign addr_oor         = 1'b0;
   assign unused_addr_bits = ^{d_address[31:DEPTH_LOG2+2], d_address[1:0]};
`endif

   // Decode the request; out-of-range reads return zero instead of array data.
   always_comb begin
      wr_en   = d_data_valid & d_write_enable & ~addr_oor;
      rd_en   = d_data_valid & ~d_write_enable;
      rd_word = addr_oor ? 32'd0 : mem_q[word_idx];
   end

   // Array write; reset only blocks writes, the contents are kept across reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // array intentionally untouched
      end else if (wr_en) begin
         mem_q[word_idx] <= d_data_write;
      end
   end

   // Response pipeline: LATENCY-1 intermediate {valid, data} stages feed the output register.
   generate
      if (LATENCY == 1) begin : g_lat1
         // With a single cycle of latency the array read goes straight to the output register.
         always_comb begin
            fin_vld = rd_en;
            fin_dat = rd_word;
         end
      end else begin : g_latn
         logic        pipe_vld_q [1:LATENCY-1];
         logic        pipe_vld_d [1:LATENCY-1];
         logic [31:0] pipe_dat_q [1:LATENCY-1];
         logic [31:0] pipe_dat_d [1:LATENCY-1];

         // Shift: stage 1 takes the fresh read (or a bubble), later stages take their predecessor.
         always_comb begin
            pipe_vld_d[1] = rd_en;
            pipe_dat_d[1] = rd_word;
            for (int s = 2; s <= LATENCY-1; s++) begin
               pipe_vld_d[s] = pipe_vld_q[s-1];
               pipe_dat_d[s] = pipe_dat_q[s-1];
            end
            fin_vld = pipe_vld_q[LATENCY-1];
            fin_dat = pipe_dat_q[LATENCY-1];
         end

         // Pipeline stage registers; reset discards reads in flight.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int s = 1; s <= LATENCY-1; s++) begin
                  pipe_vld_q[s] <= 1'b0;
                  pipe_dat_q[s] <= 32'd0;
               end
            end else begin
               for (int s = 1; s <= LATENCY-1; s++) begin
                  pipe_vld_q[s] <= pipe_vld_d[s];
                  pipe_dat_q[s] <= pipe_dat_d[s];
               end
            end
         end
      end
   endgenerate

   // Output stage: pulse valid for one cycle and hold read data between responses.
   always_comb begin
      rsp_valid_d = fin_vld;
      data_read_d = fin_vld ? fin_dat : data_read_q;
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         data_read_q <= 32'd0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         data_read_q <= data_read_d;
      end
   end

   assign d_rsp_valid = rsp_valid_q;
   assign d_data_read = data_read_q;

`ifdef DMEM_RANGE_CHECK_EN
   logic err_q;
   logic err_d;

   // Sticky error: any out-of-range request, read or write, sets it until reset.
   always_comb begin
      err_d = err_q | (d_data_valid & addr_oor);
   end

   // Error flag register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign d_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives three responders (LATENCY 1, 2, 3) with identical traffic.
// Expected read data and arrival cycles are queued per instance when a read is issued.
// Responses are popped and compared on the falling edge; data hold is checked every idle cycle.
`timescale 1ns/1ps
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] d_address;
   logic [31:0] d_data_write;
   logic        d_write_enable;
   logic        d_data_valid;
   logic [31:0] dr1, dr2, dr3;
   logic        rv1, rv2, rv3;
`ifdef DMEM_RANGE_CHECK_EN
   logic        er1, er2, er3;
`endif

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
      .clk(clk), .reset_n(reset_n), .d_address(d_address), .d_data_write(d_data_write),
      .d_write_enable(d_write_enable), .d_data_valid(d_data_valid), .d_data_read(dr1),
`ifdef DMEM_RANGE_CHECK_EN
      .d_rsp_valid(rv1), .d_err(er1)
`else
      .d_rsp_valid(rv1)
`endif
   );

   dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
      .clk(clk), .reset_n(reset_n), .d_address(d_address), .d_data_write(d_data_write),
      .d_write_enable(d_write_enable), .d_data_valid(d_data_valid), .d_data_read(dr2),
`ifdef DMEM_RANGE_CHECK_EN
      .d_rsp_valid(rv2), .d_err(er2)
`else
      .d_rsp_valid(rv2)
`endif
   );

   dmem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
      .clk(clk), .reset_n(reset_n), .d_address(d_address), .d_data_write(d_data_write),
      .d_write_enable(d_write_enable), .d_data_valid(d_data_valid), .d_data_read(dr3),
`ifdef DMEM_RANGE_CHECK_EN
      .d_rsp_valid(rv3), .d_err(er3)
`else
      .d_rsp_valid(rv3)
`endif
   );

   typedef struct {
      int          due;
      logic [31:0] dat;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   exp_t        q3[$];
   logic [31:0] last_rsp [3];
   logic [31:0] ref_mem [1024];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic addr_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
      return |a[31:12];
`else
      return 1'b0;
`endif
   endfunction

   task automatic push_exp(input logic [31:0] dat);
      exp_t e;
      e.dat = dat;
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 2; q2.push_back(e);
      e.due = cyc + 3; q3.push_back(e);
   endtask

   task automatic pop_exp(input int li);
      case (li)
         1: void'(q1.pop_front());
         2: void'(q2.pop_front());
         default: void'(q3.pop_front());
      endcase
   endtask

   task automatic flush_exp();
      q1.delete(); q2.delete(); q3.delete();
      for (int i = 0; i < 3; i++) last_rsp[i] = 32'd0;
   endtask

   // Compare one instance's outputs against the head of its scoreboard queue.
   task automatic scb_step(input int li, input logic vld, input logic [31:0] dat);
      exp_t  e;
      bit    have;
      string nm;
      have = 1'b0;
      e.due = 0;
      e.dat = 32'd0;
      nm = $sformatf("L%0d", li);
      case (li)
         1: if (q1.size() != 0) begin e = q1[0]; have = 1'b1; end
         2: if (q2.size() != 0) begin e = q2[0]; have = 1'b1; end
         default: if (q3.size() != 0) begin e = q3[0]; have = 1'b1; end
      endcase
      if (vld !== 1'b0) begin
         if (!have) begin
            chk({nm, " unexpected_rsp_valid"}, {31'd0, vld}, 32'd0);
            last_rsp[li-1] = dat;
         end else begin
            chk({nm, " rsp_valid"}, {31'd0, vld}, 32'd1);
            chk({nm, " rsp_cycle"}, cyc, e.due);
            chk({nm, " rsp_data"}, dat, e.dat);
            last_rsp[li-1] = e.dat;
            pop_exp(li);
         end
      end else begin
         chk({nm, " data_hold"}, dat, last_rsp[li-1]);
         if (have && cyc >= e.due) begin
            chk({nm, " rsp_valid_at_due"}, {31'd0, vld}, 32'd1);
            pop_exp(li);
         end
      end
   endtask

   always @(negedge clk) begin
      scb_step(1, rv1, dr1);
      scb_step(2, rv2, dr2);
      scb_step(3, rv3, dr3);
   end

   task automatic wr(input logic [31:0] addr, input logic [31:0] dat);
      @(posedge clk); #1;
      d_data_valid   = 1'b1;
      d_write_enable = 1'b1;
      d_address      = addr;
      d_data_write   = dat;
      if (!addr_oor(addr)) ref_mem[addr[11:2]] = dat;
   endtask

   task automatic rd(input logic [31:0] addr);
      @(posedge clk); #1;
      d_data_valid   = 1'b1;
      d_write_enable = 1'b0;
      d_address      = addr;
      d_data_write   = $urandom;
      push_exp(addr_oor(addr) ? 32'd0 : ref_mem[addr[11:2]]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         d_data_valid   = 1'b0;
         d_write_enable = 1'($urandom);
         d_address      = {20'd0, 12'($urandom)};
         d_data_write   = $urandom;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n        = 1'b0;
      d_data_valid   = 1'b0;
      d_write_enable = 1'b0;
      d_address      = 32'd0;
      d_data_write   = 32'd0;
      flush_exp();
      repeat (3) @(posedge clk);
      #1;
      chk("reset L1 data", dr1, 32'd0);
      chk("reset L3 data", dr3, 32'd0);
      chk("reset L2 rsp_valid", {31'd0, rv2}, 32'd0);
`ifdef DMEM_RANGE_CHECK_EN
      chk("reset L1 err", {31'd0, er1}, 32'd0);
`endif
      reset_n = 1'b1;
      idle(2);

      // write then read next cycle
      wr(32'h0000_0010, 32'hDEADBEEF);
      rd(32'h0000_0010);
      idle(4);

      // misaligned read, bubble between reads
      wr(32'h0000_0010, 32'hCAFEF00D);
      rd(32'h0000_0013);
      idle(1);
      rd(32'h0000_0011);
      idle(4);

      // back-to-back reads, then hold of the last response
      wr(32'h0000_0000, 32'h0000_0011);
      wr(32'h0000_0004, 32'h0000_0022);
      wr(32'h0000_0008, 32'h0000_0033);
      wr(32'h0000_000C, 32'h0000_0044);
      rd(32'h0000_0000);
      rd(32'h0000_0004);
      rd(32'h0000_0008);
      rd(32'h0000_000C);
      idle(6);
      chk("hold L1 last", dr1, 32'h0000_0044);
      chk("hold L2 last", dr2, 32'h0000_0044);
      chk("hold L3 last", dr3, 32'h0000_0044);

      // mixed random traffic over 16 words
      for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom);
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 2))
            0: idle(1);
            1: wr({26'd0, 4'($urandom), 2'($urandom)}, $urandom);
            default: rd({26'd0, 4'($urandom), 2'($urandom)});
         endcase
      end
      idle(5);

      // reset with a read in flight; writes presented during reset must be dropped
      rd(32'h0000_0010);
      @(posedge clk); #1;
      reset_n        = 1'b0;
      d_data_valid   = 1'b1;
      d_write_enable = 1'b1;
      d_address      = 32'h0000_0010;
      d_data_write   = 32'h0BAD0BAD;
      flush_exp();
      #1;
      chk("midreset L1 data", dr1, 32'd0);
      chk("midreset L2 data", dr2, 32'd0);
      chk("midreset L3 data", dr3, 32'd0);
      chk("midreset L1 rsp_valid", {31'd0, rv1}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n      = 1'b1;
      d_data_valid = 1'b0;
      idle(4);
      rd(32'h0000_0010);
      idle(4);

      // range check / aliasing at DEPTH_LOG2=10
`ifdef DMEM_RANGE_CHECK_EN
      wr(32'h0000_1000, 32'h12345678);
      @(negedge clk);
      chk("err before sample", {31'd0, er2}, 32'd0);
      rd(32'h0000_1000);
      #1;
      chk("err L1 set", {31'd0, er1}, 32'd1);
      chk("err L2 set", {31'd0, er2}, 32'd1);
      chk("err L3 set", {31'd0, er3}, 32'd1);
      rd(32'h0000_0000);
      idle(6);
      chk("err L1 sticky", {31'd0, er1}, 32'd1);
      chk("err L3 sticky", {31'd0, er3}, 32'd1);
`else
      wr(32'h0000_1000, 32'h12345678);
      rd(32'h0000_0000);
      rd(32'h0000_1000);
      idle(6);
`endif

      chk("L1 queue drained", q1.size(), 32'd0);
      chk("L2 queue drained", q2.size(), 32'd0);
      chk("L3 queue drained", q3.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
